// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
//   Shared types and helpers for the FIFO-fed UART transmitter.
//   - state_t     : transmitter FSM states.
//   - FRAME_BITS  : serial bit times in a frame of the default configuration
//                   (start + 8 data + no parity + 1 stop).
//   - parity_calc : parity of up to MAX_DATA_W data bits, even or odd.
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int MAX_DATA_W = 32;
   localparam int FRAME_BITS = 1 + 8 + 0 + 1;

   // Narrower words are zero-extended by the caller; zeros do not change the XOR.
   function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-time counter: counts 0..CLKS_PER_BIT-1 and wraps, marking the final
//   cycle of every serial bit.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   clear        holds the counter at zero (used while no bit is on the line)
//   bit_end      high in the last cycle of the current bit time
//   bit_end_next high one cycle before bit_end
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end,
   output logic bit_end_next
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_end      = (cnt == CNT_LAST);
   assign bit_end_next = (cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drains a FIFO one word at a time and serialises each word as a UART frame:
//   start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   en          allows a new frame to start; a running frame always completes
//   fifo_empty  FIFO empty flag, looked at only in IDLE
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle read strobe per frame
//   tx          serial line, idles high
//   busy        high whenever the FSM is not in IDLE
//   frame_done  one-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   state_t            state, state_d;
   logic [DATA_W-1:0] shift_reg, shift_d;
   logic              par_bit, par_d;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
   logic              baud_clr, bit_end, bit_end_next;
   logic              tx_d, rd_en_d, busy_d, done_d;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk          (clk),
      .rst          (rst),
      .clear        (baud_clr),
      .bit_end      (bit_end),
      .bit_end_next (bit_end_next)
   );

   // Next state, then the registered outputs are derived from the next state
   // so that every output appears in the same cycle as the state it belongs to.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned, which would infer a latch.
      state_d   = state;
      shift_d   = shift_reg;
      par_d     = par_bit;
      bit_cnt_d = bit_cnt;
      baud_clr  = 1'b0;

      case (state)
         IDLE: begin
            baud_clr = 1'b1;
            if (en && !fifo_empty) state_d = POP;
         end
         POP: begin
            baud_clr = 1'b1;
            state_d  = LOAD;
         end
         LOAD: begin
            baud_clr  = 1'b1;
            shift_d   = fifo_data;
            par_d     = parity_calc(MAX_DATA_W'(fifo_data), PARITY_ODD != 0);
            bit_cnt_d = '0;
            state_d   = START;
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_reg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase

      rd_en_d = (state_d == POP);
      busy_d  = (state_d != IDLE);
      // The coming cycle is the last one of the final stop bit.
      done_d  = (state_d == STOP) && (bit_cnt_d == LAST_STOP) && bit_end_next;
   end

   // NOTE: the datapath registers are reset too, so a word popped before an
   // abort cannot leak into a later frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         par_bit    <= 1'b0;
         bit_cnt    <= '0;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         shift_reg  <= shift_d;
         par_bit    <= par_d;
         bit_cnt    <= bit_cnt_d;
         tx         <= tx_d;
         fifo_rd_en <= rd_en_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

endmodule
